// File: rtl/cla_seq_ctrl.sv
// Multi-word add/subtract sequencer driving one 32-bit carry-lookahead adder, LSW first.
// Optional macro CLA_SEQ_SUB_EN adds the sub port and two's-complement subtract.

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g, p, c;
    logic [7:0]  gg, pp, cn;
    logic [1:0]  g2, p2, cs;

    // Carries into positions 0..3 of a 4-wide lookahead group.
    function automatic logic [3:0] la_carry(input logic [3:0] gi, input logic [3:0] pi,
                                            input logic cin);
        logic [3:0] cr;
        cr[0] = cin;
        cr[1] = gi[0] | (pi[0] & cin);
        cr[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        cr[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);
        return cr;
    endfunction

    function automatic logic grp_g(input logic [3:0] gi, input logic [3:0] pi);
        return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    endfunction

    // NOTE: every variable is fully assigned before any read, so no latch can be inferred.
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int n = 0; n < 8; n++) begin
            gg[n] = grp_g(g[4*n +: 4], p[4*n +: 4]);
            pp[n] = &p[4*n +: 4];
        end
        for (int m = 0; m < 2; m++) begin
            g2[m] = grp_g(gg[4*m +: 4], pp[4*m +: 4]);
            p2[m] = &pp[4*m +: 4];
        end
        cs[0] = ci;
        cs[1] = g2[0] | (p2[0] & ci);
        co    = g2[1] | (p2[1] & g2[0]) | (p2[1] & p2[0] & ci);
        for (int m = 0; m < 2; m++) begin
            cn[4*m +: 4] = la_carry(gg[4*m +: 4], pp[4*m +: 4], cs[m]);
        end
        for (int n = 0; n < 8; n++) begin
            c[4*n +: 4] = la_carry(g[4*n +: 4], p[4*n +: 4], cn[n]);
        end
        s = p ^ c;
    end
endmodule

module cla_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
`ifdef CLA_SEQ_SUB_EN
    input  logic                  sub,
`endif
    input  logic [32*WORDS-1:0]   op_a,
    input  logic [32*WORDS-1:0]   op_b,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   result,
    output logic                  co,
    output logic                  ovf
);
    localparam int W  = 32 * WORDS;
    localparam int IW = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_q, b_q, b_in;
    logic [IW-1:0]   idx;
    logic            carry_q, seed;
    logic [31:0]     a_w, b_w, s_w;
    logic            c_out, last_word;

`ifdef CLA_SEQ_SUB_EN
    assign b_in = sub ? ~op_b : op_b;
    assign seed = sub;
`else
    assign b_in = op_b;
    assign seed = 1'b0;
`endif

    assign a_w       = a_q[32*idx +: 32];
    assign b_w       = b_q[32*idx +: 32];
    assign last_word = (idx == IW'(WORDS - 1));

    cla32 u_cla (
        .a  (a_w),
        .b  (b_w),
        .ci (carry_q),
        .s  (s_w),
        .co (c_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_word) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            result  <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= b_in;
                        idx     <= '0;
                        carry_q <= seed;
                        result  <= '0;
                        co      <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                RUN: begin
                    result[32*idx +: 32] <= s_w;
                    carry_q              <= c_out;
                    idx                  <= idx + 1'b1;
                    if (last_word) begin
                        co  <= c_out;
                        // Signed overflow: like-signed operands yielding a different-signed sum.
                        ovf <= (a_w[31] == b_w[31]) && (s_w[31] != a_w[31]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
